// File: rtl/player_turn_ctrl.sv
// N-player session controller: remote link sync, player claiming, turn rotation and throw relay.
// Optional build macro TURN_TIMEOUT_EN forces a turn to advance after TIMEOUT_CYC idle cycles.
module player_turn_ctrl #(
   parameter int PLAYERS     = 2,
   parameter int POWER_W     = 5,
   parameter int TURN_W      = 8,
   parameter int TIMEOUT_CYC = 40_000_000,
   localparam int PW         = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
   input  logic               clk40MHz,
   input  logic               rst,
   input  logic [PLAYERS-1:0] in_ready,
   input  logic [PLAYERS-1:0] choose,
   input  logic               fire,
   input  logic [POWER_W-1:0] fire_power,
   input  logic [POWER_W-1:0] in_power,
   input  logic               in_throw_flag,
   input  logic               throw_done,
   input  logic               game_over,
   output logic [PLAYERS-1:0] player_led,
   output logic [PLAYERS-1:0] out_ready,
   output logic [PW-1:0]      current_player,
   output logic               player_valid,
   output logic [PW-1:0]      active_player,
   output logic [POWER_W-1:0] out_power,
   output logic               out_throw_flag,
   output logic [TURN_W-1:0]  turn,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      ST_CONNECT = 2'd0,
      ST_CHOOSE  = 2'd1,
      ST_PLAY    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PLAYERS-1:0] led_q, led_d;
   logic [PLAYERS-1:0] ready_q, ready_d;
   logic [PW-1:0]      cur_q, cur_d;
   logic               valid_q, valid_d;
   logic [PW-1:0]      active_q, active_d;
   logic [POWER_W-1:0] power_q, power_d;
   logic               flag_q, flag_d;
   logic [TURN_W-1:0]  turn_q, turn_d;
   logic               pending_q, pending_d;

   logic [PLAYERS-1:0] avail, cand_oh;
   logic [PW-1:0]      cand_idx;
   logic               conflict, local_turn, timeout_hit;

`ifdef TURN_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter restarts whenever a turn begins: PLAY entry, throw_done or its own expiry.
   assign timeout_hit = (state_q == ST_PLAY) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   assign cnt_d = ((state_q != ST_PLAY) || throw_done || timeout_hit) ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge clk40MHz) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic unused_timeout;
   assign timeout_hit    = 1'b0;
   assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

   // Remotely claimed players are masked out; cand_oh isolates the lowest free request.
   assign avail      = choose & ~in_ready;
   assign cand_oh    = avail & (~avail + PLAYERS'(1));
   assign conflict   = |(ready_q & in_ready);
   assign local_turn = valid_q && (active_q == cur_q);

   always_comb begin
      cand_idx = '0;
      for (int i = PLAYERS - 1; i >= 0; i--) begin
         if (avail[i]) cand_idx = PW'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      led_d     = led_q;
      ready_d   = ready_q;
      cur_d     = cur_q;
      valid_d   = valid_q;
      active_d  = active_q;
      power_d   = power_q;
      flag_d    = flag_q;
      turn_d    = turn_q;
      pending_d = pending_q;
      case (state_q)
         ST_CONNECT: begin
            flag_d  = 1'b1;
            power_d = '0;
            if (in_throw_flag && (in_power == '0)) begin
               state_d = ST_CHOOSE;
               led_d   = '1;
               flag_d  = 1'b0;
            end
         end
         ST_CHOOSE: begin
            if (conflict) begin
               ready_d = '0;
               valid_d = 1'b0;
               led_d   = '1;
            end else if ((ready_q != '0) && ((ready_q | in_ready) == '1)) begin
               state_d   = ST_PLAY;
               active_d  = '0;
               turn_d    = '0;
               pending_d = 1'b0;
            end else if ((avail != '0) && (cand_oh != ready_q)) begin
               ready_d = cand_oh;
               led_d   = cand_oh;
               cur_d   = cand_idx;
               valid_d = 1'b1;
               turn_d  = '0;
            end
         end
         ST_PLAY: begin
            flag_d = 1'b0;
            // Priority: game_over, then turn advance, then throw start.
            if (game_over) begin
               state_d   = ST_CHOOSE;
               ready_d   = '0;
               valid_d   = 1'b0;
               led_d     = '1;
               active_d  = '0;
               pending_d = 1'b0;
            end else if (throw_done || timeout_hit) begin
               active_d  = (active_q == PW'(PLAYERS - 1)) ? '0 : active_q + PW'(1);
               turn_d    = (turn_q == '1) ? turn_q : turn_q + TURN_W'(1);
               pending_d = 1'b0;
            end else if (fire && local_turn && !pending_q) begin
               power_d   = fire_power;
               flag_d    = 1'b1;
               pending_d = 1'b1;
            end else if (in_throw_flag && !local_turn) begin
               pending_d = 1'b1;
            end
         end
         default: begin
            state_d   = ST_CONNECT;
            led_d     = '0;
            ready_d   = '0;
            cur_d     = '0;
            valid_d   = 1'b0;
            active_d  = '0;
            power_d   = '0;
            flag_d    = 1'b1;
            turn_d    = '0;
            pending_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk40MHz) begin
      if (rst) begin
         state_q   <= ST_CONNECT;
         led_q     <= '0;
         ready_q   <= '0;
         cur_q     <= '0;
         valid_q   <= 1'b0;
         active_q  <= '0;
         power_q   <= '0;
         flag_q    <= 1'b1;
         turn_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         led_q     <= led_d;
         ready_q   <= ready_d;
         cur_q     <= cur_d;
         valid_q   <= valid_d;
         active_q  <= active_d;
         power_q   <= power_d;
         flag_q    <= flag_d;
         turn_q    <= turn_d;
         pending_q <= pending_d;
      end
   end

   assign state          = state_q;
   assign player_led     = led_q;
   assign out_ready      = ready_q;
   assign current_player = cur_q;
   assign player_valid   = valid_q;
   assign active_player  = active_q;
   assign out_power      = power_q;
   assign out_throw_flag = flag_q;
   assign turn           = turn_q;

endmodule

// File: tb/tb_player_turn_ctrl.sv
// Directed bench for player_turn_ctrl: a 2-player instance (short timeout) and a 3-player instance.
module tb_player_turn_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // 2-player instance
   logic [1:0] in_ready2, choose2, led2, ready2;
   logic       fire2, in_throw2, throw_done2, game_over2;
   logic [4:0] fire_power2, in_power2, power2;
   logic       cur2, valid2, active2, flag2;
   logic [7:0] turn2;
   logic [1:0] state2;

   // 3-player instance
   logic [2:0] in_ready3, choose3, led3, ready3;
   logic       fire3, in_throw3, throw_done3, game_over3;
   logic [4:0] fire_power3, in_power3, power3;
   logic [1:0] cur3, active3;
   logic       valid3, flag3;
   logic [7:0] turn3;
   logic [1:0] state3;

   player_turn_ctrl #(.PLAYERS(2), .POWER_W(5), .TURN_W(8), .TIMEOUT_CYC(16)) u_dut2 (
      .clk40MHz(clk), .rst(rst), .in_ready(in_ready2), .choose(choose2), .fire(fire2),
      .fire_power(fire_power2), .in_power(in_power2), .in_throw_flag(in_throw2),
      .throw_done(throw_done2), .game_over(game_over2), .player_led(led2), .out_ready(ready2),
      .current_player(cur2), .player_valid(valid2), .active_player(active2), .out_power(power2),
      .out_throw_flag(flag2), .turn(turn2), .state(state2));

   player_turn_ctrl #(.PLAYERS(3), .POWER_W(5), .TURN_W(8)) u_dut3 (
      .clk40MHz(clk), .rst(rst), .in_ready(in_ready3), .choose(choose3), .fire(fire3),
      .fire_power(fire_power3), .in_power(in_power3), .in_throw_flag(in_throw3),
      .throw_done(throw_done3), .game_over(game_over3), .player_led(led3), .out_ready(ready3),
      .current_player(cur3), .player_valid(valid3), .active_player(active3), .out_power(power3),
      .out_throw_flag(flag3), .turn(turn3), .state(state3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_ready2 = '0; choose2 = '0; fire2 = 0; fire_power2 = '0; in_power2 = '0;
      in_throw2 = 0; throw_done2 = 0; game_over2 = 0;
      in_ready3 = '0; choose3 = '0; fire3 = 0; fire_power3 = '0; in_power3 = '0;
      in_throw3 = 0; throw_done3 = 0; game_over3 = 0;
      step(); step();
      chk("rst_state", state2, 0);
      chk("rst_led", led2, 0);
      chk("rst_ready", ready2, 0);
      chk("rst_cur", cur2, 0);
      chk("rst_valid", valid2, 0);
      chk("rst_active", active2, 0);
      chk("rst_power", power2, 0);
      chk("rst_flag", flag2, 1);
      chk("rst_turn", turn2, 0);
      chk("rst_state3", state3, 0);
      rst = 1'b0;

      // Link sync needs a zero-power beacon
      in_throw2 = 1; in_power2 = 5'd5;
      step();
      chk("conn_hold_state", state2, 0);
      chk("conn_hold_flag", flag2, 1);
      in_power2 = 5'd0;
      step();
      chk("conn_exit_state", state2, 1);
      chk("conn_exit_led", led2, 2'b11);
      chk("conn_exit_flag", flag2, 0);
      in_throw2 = 0;

      // Claim player 0, then remote claims 1 -> PLAY
      choose2 = 2'b01;
      step();
      chk("claim_ready", ready2, 2'b01);
      chk("claim_cur", cur2, 0);
      chk("claim_valid", valid2, 1);
      chk("claim_led", led2, 2'b01);
      chk("claim_state", state2, 1);
      choose2 = 2'b00; in_ready2 = 2'b10;
      step();
      chk("play_state", state2, 2);
      chk("play_active", active2, 0);
      chk("play_turn", turn2, 0);

      // Local throw
      fire2 = 1; fire_power2 = 5'd17;
      step();
      chk("fire_flag", flag2, 1);
      chk("fire_power", power2, 17);
      fire2 = 0;
      step();
      chk("fire_flag_1cyc", flag2, 0);
      chk("fire_power_hold", power2, 17);
      throw_done2 = 1;
      step();
      throw_done2 = 0;
      chk("adv_active", active2, 1);
      chk("adv_turn", turn2, 1);

      // Fire on remote turn is ignored
      fire2 = 1; fire_power2 = 5'd3;
      step();
      fire2 = 0;
      chk("remote_fire_flag", flag2, 0);
      chk("remote_fire_power", power2, 17);
      in_throw2 = 1;
      step();
      in_throw2 = 0; throw_done2 = 1;
      step();
      throw_done2 = 0;
      chk("wrap_active", active2, 0);
      chk("wrap_turn", turn2, 2);

      // Simultaneous fire and throw_done: advance wins
      fire2 = 1; fire_power2 = 5'd9; throw_done2 = 1;
      step();
      fire2 = 0; throw_done2 = 0;
      chk("simul_flag", flag2, 0);
      chk("simul_active", active2, 1);
      chk("simul_turn", turn2, 3);
      chk("simul_power", power2, 17);
      throw_done2 = 1;
      step();
      throw_done2 = 0;
      chk("nopend_active", active2, 0);
      chk("nopend_turn", turn2, 4);

      // Second fire while pending is ignored
      fire2 = 1; fire_power2 = 5'd10;
      step();
      chk("pend_fire_flag", flag2, 1);
      chk("pend_fire_power", power2, 10);
      fire_power2 = 5'd11;
      step();
      fire2 = 0;
      chk("pend_refire_flag", flag2, 0);
      chk("pend_refire_power", power2, 10);
      throw_done2 = 1;
      step();
      throw_done2 = 0;
      chk("pend_clr_active", active2, 1);
      chk("pend_clr_turn", turn2, 5);

`ifdef TURN_TIMEOUT_EN
      repeat (15) step();
      chk("tmo_before_active", active2, 1);
      step();
      chk("tmo_active", active2, 0);
      chk("tmo_turn", turn2, 6);
`endif

      // Turn counter saturation
      throw_done2 = 1;
      repeat (260) step();
      chk("sat_turn", turn2, 255);
      step();
      chk("sat_turn_hold", turn2, 255);

      // game_over beats throw_done
      game_over2 = 1;
      step();
      game_over2 = 0; throw_done2 = 0;
      chk("go_state", state2, 1);
      chk("go_ready", ready2, 0);
      chk("go_valid", valid2, 0);
      chk("go_led", led2, 2'b11);
      chk("go_active", active2, 0);
      chk("go_turn", turn2, 255);

      // Conflict: remote claims the same player
      in_ready2 = 2'b00; choose2 = 2'b01;
      step();
      chk("cf_claim_ready", ready2, 2'b01);
      chk("cf_claim_turn", turn2, 0);
      in_ready2 = 2'b01;
      step();
      chk("cf_drop_ready", ready2, 0);
      chk("cf_drop_valid", valid2, 0);
      chk("cf_drop_led", led2, 2'b11);
      step();
      chk("cf_masked_ready", ready2, 0);
      choose2 = 2'b11;
      step();
      chk("cf_reclaim_ready", ready2, 2'b10);
      chk("cf_reclaim_cur", cur2, 1);
      step();
      chk("cf_play_state", state2, 2);
      chk("cf_play_active", active2, 0);
      choose2 = 2'b00; fire2 = 1; fire_power2 = 5'd7;
      step();
      fire2 = 0;
      chk("cf_remote_fire", flag2, 0);

      // Reset mid-game
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_state", state2, 0);
      chk("midrst_flag", flag2, 1);
      chk("midrst_ready", ready2, 0);
      chk("midrst_turn", turn2, 0);
      in_ready2 = '0;

      // 3-player instance
      in_throw3 = 1; in_power3 = 5'd0;
      step();
      in_throw3 = 0;
      chk("p3_choose_state", state3, 1);
      chk("p3_led", led3, 3'b111);
      choose3 = 3'b100; in_ready3 = 3'b001;
      step();
      chk("p3_claim_ready", ready3, 3'b100);
      chk("p3_claim_cur", cur3, 2);
      step();
      chk("p3_wait_state", state3, 1);
      in_ready3 = 3'b011;
      step();
      chk("p3_play_state", state3, 2);
      chk("p3_play_active", active3, 0);
      throw_done3 = 1;
      step();
      chk("p3_active1", active3, 1);
      step();
      chk("p3_active2", active3, 2);
      step();
      throw_done3 = 0;
      chk("p3_wrap", active3, 0);
      chk("p3_turn", turn3, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
